// File: rtl/vga_scanout.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : vga_scanout
// Purpose  : VGA timing generator and raster-order VRAM port-B reader with a
//            fixed two-clock alignment of pixel data and sync to the pins.
// Revision : 1.0
// ============================================================================
module vga_scanout #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CLK_DIV  = 4,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic [18:0] vram_addr,
    output logic        vram_we,
    output logic [11:0] vram_din,
    input  logic [11:0] vram_dout,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vblank,
    output logic        frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int DW      = $clog2(CLK_DIV);

    localparam logic [DW-1:0] C_DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [HW-1:0] C_H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] C_H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] C_HS_BEG   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] C_HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] C_V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] C_V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] C_VS_BEG   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] C_VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

    logic          run_q;
    logic [DW-1:0] div_q,  div_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [VW-1:0] vcnt_q, vcnt_d;
    logic [18:0]   addr_q, addr_d;
    logic          first_q, first_d;

    logic          act1_q, hs1_q, vs1_q, vb1_q, fs1_q;
    logic [11:0]   rgb_q;
    logic          hs_q, vs_q, vblank_q, fs_q;

    logic          w_tick;
    logic          w_frame_wrap;
    logic          w_act0, w_hs0, w_vs0, w_vb0;

    assign w_tick       = run_q && (div_q == C_DIV_LAST);
    assign w_frame_wrap = w_tick && (hcnt_q == C_H_LAST) && (vcnt_q == C_V_LAST);

    // The first edge that sees en high only arms run_q, so pixel (0,0) gets a full CLK_DIV clocks.
    always_comb begin
        div_d   = div_q;
        hcnt_d  = hcnt_q;
        vcnt_d  = vcnt_q;
        addr_d  = addr_q;
        first_d = 1'b0;
        if (!en) begin
            div_d  = '0;
            hcnt_d = '0;
            vcnt_d = '0;
            addr_d = '0;
        end else if (run_q) begin
            div_d = w_tick ? '0 : div_q + DW'(1);
            if (w_tick) begin
                if (hcnt_q == C_H_LAST) begin
                    hcnt_d = '0;
                    vcnt_d = (vcnt_q == C_V_LAST) ? '0 : vcnt_q + VW'(1);
                end else begin
                    hcnt_d = hcnt_q + HW'(1);
                end
                first_d = w_frame_wrap;
                // Raster order means the next visible pixel is always the previous address plus one.
                if (w_frame_wrap) begin
                    addr_d = '0;
                end else if ((hcnt_d < C_H_ACT) && (vcnt_d < C_V_ACT)) begin
                    addr_d = addr_q + 19'd1;
                end
            end
        end
    end

    assign w_act0 = run_q && (hcnt_q < C_H_ACT) && (vcnt_q < C_V_ACT);
    assign w_hs0  = run_q && (hcnt_q >= C_HS_BEG) && (hcnt_q < C_HS_END);
    assign w_vs0  = run_q && (vcnt_q >= C_VS_BEG) && (vcnt_q < C_VS_END);
    assign w_vb0  = run_q && (vcnt_q >= C_V_ACT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q    <= 1'b0;
            div_q    <= '0;
            hcnt_q   <= '0;
            vcnt_q   <= '0;
            addr_q   <= '0;
            first_q  <= 1'b0;
            act1_q   <= 1'b0;
            hs1_q    <= 1'b0;
            vs1_q    <= 1'b0;
            vb1_q    <= 1'b0;
            fs1_q    <= 1'b0;
            rgb_q    <= '0;
            hs_q     <= ~SYNC_POL;
            vs_q     <= ~SYNC_POL;
            vblank_q <= 1'b0;
            fs_q     <= 1'b0;
        end else begin
            run_q    <= en;
            div_q    <= div_d;
            hcnt_q   <= hcnt_d;
            vcnt_q   <= vcnt_d;
            addr_q   <= addr_d;
            first_q  <= first_d;
            // Stage 1 lines up with the VRAM read latency; stage 2 drives the pins.
            act1_q   <= w_act0;
            hs1_q    <= w_hs0;
            vs1_q    <= w_vs0;
            vb1_q    <= w_vb0;
            fs1_q    <= first_q;
            rgb_q    <= act1_q ? vram_dout : 12'h000;
            hs_q     <= hs1_q ? SYNC_POL : ~SYNC_POL;
            vs_q     <= vs1_q ? SYNC_POL : ~SYNC_POL;
            vblank_q <= vb1_q;
            fs_q     <= fs1_q;
        end
    end

    assign vram_addr   = addr_q;
    assign vram_we     = 1'b0;
    assign vram_din    = 12'h000;
    assign vga_r       = rgb_q[11:8];
    assign vga_g       = rgb_q[7:4];
    assign vga_b       = rgb_q[3:0];
    assign vga_hs      = hs_q;
    assign vga_vs      = vs_q;
    assign vblank      = vblank_q;
    assign frame_start = fs_q;

endmodule
`default_nettype wire

// File: doc/vga_scanout.md
Name: vga_scanout

Overview:
- Display-side controller for the 12-bit VRAM's second (read-only) port.
- Generates VGA timing from the system clock using a pixel-tick divider.
- Sequences VRAM read addresses in raster order and pipelines read data and sync signals to the pins with fixed alignment.
- Sits between the VRAM port B and the board VGA connector; the CPU side keeps VRAM port A.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- CLK_DIV, 4, system clocks per pixel; legal range >= 3
- SYNC_POL, 0, sync active level; 0 = active-low

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  scan enable
- vram_addr  out  19  to VRAM addrb
- vram_we  out  1  to VRAM web; tied 0
- vram_din  out  12  to VRAM dinb; tied 0
- vram_dout  in  12  from VRAM doutb; RGB444 = {R[11:8], G[7:4], B[3:0]}
- vga_r  out  4  red
- vga_g  out  4  green
- vga_b  out  4  blue
- vga_hs  out  1  horizontal sync
- vga_vs  out  1  vertical sync
- vblank  out  1  high while the output line is outside the active region
- frame_start  out  1  one-clk pulse at the first output pixel of a frame

Behaviour:
- Interface: one clock, `clk`; reset `rst_n` is asynchronous and active-low.
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Divider: div counts 0..CLK_DIV-1 and wraps. tick = (div == CLK_DIV-1).
- Counters: hcnt and vcnt advance only on tick.
  - hcnt wraps at H_TOTAL-1 to 0.
  - On hcnt wrap, vcnt increments, wrapping at V_TOTAL-1 to 0.
- Regions:
  - active = (hcnt < H_ACTIVE) && (vcnt < V_ACTIVE).
  - hs_raw asserted for H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC.
  - vs_raw asserted for V_ACTIVE+V_FP <= vcnt < V_ACTIVE+V_FP+V_SYNC.
- Address:
  - vram_addr is registered and updates on the same edge as the counters.
  - Equals vcnt*H_ACTIVE+hcnt while active; holds its last value during blanking.
  - Equals 0 whenever (hcnt,vcnt) = (0,0).
  - Must be an incremental counter; no multiplier. Max value 307199, fits 19 bits.
- Pipeline (fixed, regardless of CLK_DIV):
  - Edge E: counters and address update.
  - E+1: VRAM data valid.
  - E+2: vga_r/g/b, vga_hs, vga_vs, vblank and frame_start register.
  - active, hs_raw, vs_raw and first-pixel flags are delayed two clocks to match.
- Colour: outputs = vram_dout fields when the delayed active flag is set, else 0.
- Sync level: pin level = SYNC_POL when asserted, ~SYNC_POL otherwise.
- frame_start: single-clk pulse, delayed the same two clocks, marking the clock at which (hcnt,vcnt) became (0,0) via wrap.
- en low:
  - div, hcnt, vcnt, vram_addr forced to 0 synchronously.
  - Colour 0, syncs inactive, vblank 0, frame_start 0 after the pipeline drains (two clocks).
- en rising: scanning starts at (0,0). The first tick occurs CLK_DIV clocks after en is seen high. No frame_start pulse for this first frame.
- Reset (async, any time including mid-frame):
  - div = hcnt = vcnt = vram_addr = 0.
  - vga_r/g/b = 0, vga_hs = vga_vs = ~SYNC_POL (1 with defaults), vblank = 0, frame_start = 0.
  - All pipeline flags cleared.
- vram_we and vram_din constant 0 always; this block never writes VRAM.

Test Plan:
- Reset and enable: reset released, en=1, defaults. vram_addr=0, hs=vs=1. First tick at clk 4. vram_addr=1 at the tick with hcnt=1.
- Line timing: run one line. vga_hs low for exactly 96*4=384 clks, starting 656*4 clks after the hcnt=0 tick plus 2 clks of pipeline. Line period 3200 clks.
- Frame timing: run one frame. vga_vs low for 2 lines (6400 clks). frame_start pulses once per 1,680,000 clks. vblank high for 45 lines.
- Data path:
  - VRAM model returns data = addr[11:0], with a 1-clk latency model.
  - At pixel (5,1), address 645 → vga_r/g/b = 4'h2/4'h8/4'h5, two clks after the address edge.
  - Blanking pixels → colour 0.
- Wrap: last active pixel (639,479) gives vram_addr=307199. The address holds through blanking and returns to 0 at (0,0).
- Mid-frame disturbance:
  - Assert rst_n=0 at line 200. All outputs return to reset values asynchronously, with no glitch cycle.
  - Dropping en at line 200 blanks outputs after 2 clks; restart resumes from (0,0).
